addsub_rr_scheduler: RTL and testbench
======================================

// Module: addsub_rr_scheduler
// PURPOSE
//  Shares one 8-bit add/sub accumulate datapath among NREQ requesters.
//  Each job carries four operands (a,b,c,d) and a mode bit.
//  The scheduler arbitrates round-robin, captures the winner's operands, then sequences
//  load/op/op/op steps over the shared accumulator. Result, overflow and requester ID are
//  returned with a one-cycle done pulse. Sits between client FSMs and the add/sub unit.
// PARAMETERS
//  W     8  operand/result width (bits)
//  NREQ  2  number of requesters; legal range 2..4
// PORTS
//  clock    in   1       clock; all state changes on rising edge
//  reset    in   1       asynchronous, active-high reset
//  req      in   NREQ    per-requester job request, level
//  mode     in   NREQ    per-requester op: 0 = add, 1 = subtract
//  op_a     in   NREQ*W  flattened a operands; requester i at [i*W +: W] (same for b/c/d)
//  op_b     in   NREQ*W  flattened b operands
//  op_c     in   NREQ*W  flattened c operands
//  op_d     in   NREQ*W  flattened d operands
//  gnt      out  NREQ    one-hot grant, registered, high exactly 1 cycle per job
//  busy     out  1       high in every state except IDLE
//  done     out  1       one-cycle pulse: result/ovf/done_id valid
//  done_id  out  2       index of requester whose job completed
//  result   out  W       final accumulator value, held until next done
//  ovf      out  1       sticky signed overflow of the job, held with result
// BEHAVIOUR
//  Reset values: gnt=0, busy=0, done=0, done_id=0, result=0, ovf=0, acc=0, state=IDLE,
//   rr pointer=NREQ-1 (so req[0] wins first).
//  States: IDLE -> LOAD -> OP1 -> OP2 -> OP3 -> DONE -> IDLE.
//  IDLE: if req!=0 at an edge, pick winner = first set req searching from ptr+1 upward
//   (mod NREQ). Capture winner's a,b,c,d,mode. Set gnt[winner]; ptr<=winner; go LOAD.
//   If req==0, stay IDLE.
//  LOAD: gnt high this cycle only; acc<=a; ovf_int<=0.
//  OP1/OP2/OP3: acc <= acc + x (mode 0) or acc - x (mode 1); x = b, c, d respectively.
//   Arithmetic is modulo 2^W. ovf_int |= signed two's-complement overflow of that step.
//  Entering DONE: result<=final acc, ovf<=ovf_int, done_id<=winner.
//   done=1 for the DONE cycle only.
//  Latency: req seen at edge 0 -> gnt during cycle 1 -> done during cycle 5.
//   Job occupancy is 6 cycles.
//  Requests are sampled only in IDLE; req changes during LOAD..DONE are ignored.
//   A requester must drop req after seeing gnt; a req still high at IDLE is a new job.
//  Operands need be stable only at the granting edge; later changes do not affect the job.
//  Simultaneous requests: round-robin; a requester that keeps re-requesting never blocks
//   others for more than NREQ-1 jobs.
//  Reset mid-job: immediate return to reset values; the job is discarded, no done pulse.
//  mode and operands of non-winning requesters are don't-care.
// CONFIGURATION
//  ADDSUB_SCHED_BACK2BACK_EN defined:
//   DONE arbitrates like IDLE (same rr rule, sampled at the DONE edge). If req!=0, go
//   directly to LOAD with gnt for the new winner; sustained throughput is 1 job / 5 cycles.
//   busy stays high across back-to-back jobs.
//  Undefined: DONE always returns to IDLE; 1 job / 6 cycles max.
// TESTING
//  1. req[0], mode 0, a=10,b=20,c=30,d=40 -> gnt=01 in cycle 1; done in cycle 5;
//     result=100, ovf=0, done_id=0.
//  2. req[1], mode 1, a=5,b=1,c=1,d=1 -> result=2, ovf=0, done_id=1.
//  3. Mode 0, a=0x7F,b=1,c=0,d=0 -> result=0x80, ovf=1.
//     Mode 0, a=0xFF,b=1,c=0,d=0 -> result=0x00, ovf=0.
//  4. req=11 held continuously -> grant order 0,1,0,1. Each done_id matches its gnt.
//     Done pulses are 6 cycles apart, or 5 with ADDSUB_SCHED_BACK2BACK_EN.
//  5. Reset asserted in OP2 -> all outputs 0 next cycle, no done.
//     First job after reset is granted to req[0].
//  6. Operands changed the cycle after gnt -> result reflects values at the grant edge.

Source files
------------

// File: rtl/addsub_rr_scheduler.sv
// addsub_rr_scheduler: round-robin sharing of one add/sub accumulate datapath among NREQ requesters.
// Optional ADDSUB_SCHED_BACK2BACK_EN lets DONE arbitrate directly into the next job.
module addsub_rr_scheduler #(
  parameter int W    = 8,
  parameter int NREQ = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   mode,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ*W-1:0] op_c,
  input  logic [NREQ*W-1:0] op_d,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_id,
  output logic [W-1:0]      result,
  output logic              ovf
);
  typedef enum logic [2:0] {IDLE, LOAD, OP1, OP2, OP3, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, win_q, win_d, win;
  logic mode_q, mode_d, ovf_int_q, ovf_int_d, ovf_q, ovf_d, found, arb_en, step_ovf;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, acc_q, acc_d, result_q, result_d, x, sum;
  logic [NREQ-1:0] gnt_q, gnt_d, sel;
  logic [1:0] done_id_q, done_id_d;
`ifdef ADDSUB_SCHED_BACK2BACK_EN
  assign arb_en = (state_q == IDLE) || (state_q == DONE);
`else
  assign arb_en = (state_q == IDLE);
`endif
  // First set request searching upward from the requester after the last winner
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = NREQ'(1) << ((int'(ptr_q) + k) % NREQ);
      if (!found && |(req & sel)) begin
        found = 1'b1;
        win   = 2'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  assign x        = (state_q == OP1) ? b_q : (state_q == OP2) ? c_q : d_q;
  assign sum      = mode_q ? acc_q - x : acc_q + x;
  assign step_ovf = (mode_q ? (acc_q[W-1] != x[W-1]) : (acc_q[W-1] == x[W-1])) && (sum[W-1] != acc_q[W-1]);
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    mode_d    = mode_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    acc_d     = acc_q;
    ovf_int_d = ovf_int_q;
    gnt_d     = '0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: state_d = IDLE;
      LOAD: begin
        acc_d     = a_q;
        ovf_int_d = 1'b0;
        state_d   = OP1;
      end
      OP1, OP2: begin
        acc_d     = sum;
        ovf_int_d = ovf_int_q | step_ovf;
        state_d   = (state_q == OP1) ? OP2 : OP3;
      end
      OP3: begin
        acc_d     = sum;
        ovf_int_d = ovf_int_q | step_ovf;
        result_d  = sum;
        ovf_d     = ovf_int_q | step_ovf;
        done_id_d = win_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (arb_en && found) begin
      state_d = LOAD;
      gnt_d   = NREQ'(1) << win;
      ptr_d   = win;
      win_d   = win;
      mode_d  = |(mode & gnt_d);
      a_d     = op_a[int'(win)*W +: W];
      b_d     = op_b[int'(win)*W +: W];
      c_d     = op_c[int'(win)*W +: W];
      d_d     = op_d[int'(win)*W +: W];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'(NREQ - 1);
      win_q     <= '0;
      mode_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      acc_q     <= '0;
      ovf_int_q <= 1'b0;
      gnt_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      acc_q     <= acc_d;
      ovf_int_q <= ovf_int_d;
      gnt_q     <= gnt_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
    end
  end
  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign result  = result_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// tb_addsub_rr_scheduler: randomized self-checking bench against an integer-arithmetic job model.
module tb_addsub_rr_scheduler;
  localparam int W = 8, NREQ = 2, BW = NREQ * W;
`ifdef ADDSUB_SCHED_BACK2BACK_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = 6;
`endif
  logic clock = 1'b0, reset;
  logic [NREQ-1:0] req, mode, gnt;
  logic [BW-1:0] op_a, op_b, op_c, op_d;
  logic busy, done, ovf;
  logic [1:0] done_id;
  logic [W-1:0] result;
  int checks = 0, fails = 0, last = NREQ - 1;

  always #5 clock = ~clock;

  addsub_rr_scheduler #(.W(W), .NREQ(NREQ)) dut (
    .clock(clock), .reset(reset), .req(req), .mode(mode),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result), .ovf(ovf)
  );

  // Signed integer evaluation with range check; returns {ovf, result}
  function automatic logic [8:0] ref_job(input logic [7:0] a, b, c, d, input logic m);
    int s, xs[3];
    logic o;
    s = int'($signed(a));
    xs[0] = int'($signed(b));
    xs[1] = int'($signed(c));
    xs[2] = int'($signed(d));
    o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = m ? s - xs[i] : s + xs[i];
      if (s > 127) begin o = 1'b1; s -= 256; end
      if (s < -128) begin o = 1'b1; s += 256; end
    end
    return {o, 8'(s)};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic scramble();
    op_a = BW'($urandom); op_b = BW'($urandom);
    op_c = BW'($urandom); op_d = BW'($urandom);
    mode = NREQ'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; req = '0;
    @(negedge clock);
    reset = 1'b0; last = NREQ - 1;
  endtask

  task automatic do_job(input logic [NREQ-1:0] mask, input logic [7:0] a, b, c, d, input logic m, input string name);
    int w, n;
    logic [8:0] e;
    w = pick(mask);
    scramble();
    op_a[w*W +: W] = a; op_b[w*W +: W] = b; op_c[w*W +: W] = c; op_d[w*W +: W] = d;
    mode[w] = m;
    req = mask;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (gnt !== (NREQ'(1) << w)) begin fails++; $display("FAIL %s gnt: got %b expected %b", name, gnt, NREQ'(1) << w); end
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy: got %b expected 1", name, busy); end
    last = w;
    e = ref_job(a, b, c, d, m);
    req = '0;
    scramble();
    n = 1;
    while (done !== 1'b1 && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (n != 5) begin fails++; $display("FAIL %s latency: got cycle %0d expected 5", name, n); end
    checks++;
    if (result !== e[7:0]) begin fails++; $display("FAIL %s result: got %h expected %h", name, result, e[7:0]); end
    checks++;
    if (ovf !== e[8]) begin fails++; $display("FAIL %s ovf: got %b expected %b", name, ovf, e[8]); end
    checks++;
    if (done_id !== 2'(w)) begin fails++; $display("FAIL %s done_id: got %0d expected %0d", name, done_id, w); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s idle: got done=%b busy=%b expected 0 0", name, done, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; mode = '0; op_a = '0; op_b = '0; op_c = '0; op_d = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({gnt, busy, done, done_id, result, ovf} !== '0) begin
      fails++; $display("FAIL reset_values: got gnt=%b busy=%b done=%b id=%0d result=%h ovf=%b expected all 0", gnt, busy, done, done_id, result, ovf);
    end
    reset = 1'b0; last = NREQ - 1;
  endtask

  task automatic test_basic();
    do_job(2'b01, 8'd10, 8'd20, 8'd30, 8'd40, 1'b0, "add_100");
    checks++;
    if (result !== 8'd100) begin fails++; $display("FAIL add_100 const: got %0d expected 100", result); end
    do_job(2'b10, 8'd5, 8'd1, 8'd1, 8'd1, 1'b1, "sub_2");
    checks++;
    if (result !== 8'd2) begin fails++; $display("FAIL sub_2 const: got %0d expected 2", result); end
    do_job(2'b01, 8'h7F, 8'd1, 8'd0, 8'd0, 1'b0, "ovf_7f");
    checks++;
    if (ovf !== 1'b1 || result !== 8'h80) begin fails++; $display("FAIL ovf_7f const: got %h/%b expected 80/1", result, ovf); end
    do_job(2'b01, 8'hFF, 8'd1, 8'd0, 8'd0, 1'b0, "wrap_ff");
    do_job(2'b10, 8'h80, 8'd1, 8'd0, 8'd0, 1'b1, "sub_ovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    int gq[$], dq[$], tq[$], rq[$], cyc, w;
    logic [7:0] a[NREQ], b[NREQ], c[NREQ], d[NREQ];
    logic [8:0] e;
    apply_reset();
    scramble();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = op_a[i*W +: W]; b[i] = op_b[i*W +: W]; c[i] = op_c[i*W +: W]; d[i] = op_d[i*W +: W];
    end
    req = '1;
    cyc = 0;
    while (dq.size() < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
      if (done) begin dq.push_back(int'(done_id)); tq.push_back(cyc); rq.push_back(int'({ovf, result})); end
    end
    req = '0;
    checks++;
    if (dq.size() != 4 || gq.size() != 4) begin fails++; $display("FAIL b2b count: got %0d grants %0d dones expected 4 4", gq.size(), dq.size()); end
    for (int i = 0; i < 4 && i < dq.size() && i < gq.size(); i++) begin
      w = pick('1);
      last = w;
      e = ref_job(a[w], b[w], c[w], d[w], mode[w]);
      checks++;
      if (gq[i] != w) begin fails++; $display("FAIL b2b order[%0d]: got %0d expected %0d", i, gq[i], w); end
      checks++;
      if (dq[i] != w) begin fails++; $display("FAIL b2b done_id[%0d]: got %0d expected %0d", i, dq[i], w); end
      checks++;
      if (rq[i] != int'(e)) begin fails++; $display("FAIL b2b result[%0d]: got %h expected %h", i, rq[i], e); end
      if (i > 0) begin
        checks++;
        if (tq[i] - tq[i-1] != SPACING) begin fails++; $display("FAIL b2b spacing[%0d]: got %0d expected %0d", i, tq[i] - tq[i-1], SPACING); end
      end
    end
    cyc = 0;
    while (busy && cyc < 20) begin @(negedge clock); cyc++; end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b drain: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_job();
    int seen;
    scramble();
    req = 2'b01;
    @(posedge clock);
    @(negedge clock);
    req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, done, done_id, result, ovf} !== '0) begin
      fails++; $display("FAIL mid_reset outputs: got gnt=%b busy=%b done=%b id=%0d result=%h ovf=%b expected all 0", gnt, busy, done, done_id, result, ovf);
    end
    @(negedge clock);
    reset = 1'b0; last = NREQ - 1;
    seen = 0;
    repeat (8) begin @(negedge clock); if (done) seen++; end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL mid_reset no_done: got %0d pulses expected 0", seen); end
    do_job(2'b11, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "post_reset");
    checks++;
    if (done_id !== 2'd0) begin fails++; $display("FAIL post_reset winner: got %0d expected 0", done_id); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
